qsys_pio_gpio_edge: RTL and testbench
=====================================

Name: qsys_pio_gpio_edge

Overview:
- Parametrised successor to the single-bit output PIO used for LCD/peripheral control lines.
- Provides a WIDTH-bit output register with atomic set/clear and a synchronised WIDTH-bit input with per-bit edge capture and a maskable interrupt.
- Sits as an Avalon-MM slave in the Qsys system, driven by the Nios II. Its readdata is combinational with zero wait states and zero read latency.

Parameters:
- WIDTH, 8: port width in bits, legal range 1..32.
- RESET_VALUE, 0: reset value of the output register; only bits WIDTH-1:0 are used.
- EDGE_TYPE, 0: edge that sets capture bits; 0 = rising, 1 = falling, 2 = any.
- SYNC_STAGES, 2: input synchroniser depth, legal range 2..4.

Ports:
- clk  in  1  system clock; all flops on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  register word offset.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data; combinational from address.
- in_port  in  WIDTH  asynchronous external inputs.
- out_port  out  WIDTH  output register contents.
- irq  out  1  level interrupt, active high.

Behaviour:
- Write strobe wr = chipselect & ~write_n. Register at address N is written only when wr and address == N.
- Register map (unused readdata bits 31:WIDTH read 0):
  - 0 DATA_OUT, R/W: write loads writedata[WIDTH-1:0].
  - 1 DATA_IN, RO: synchronised input value. Writes ignored.
  - 2 IRQ_MASK, R/W: bit = 1 enables the corresponding capture bit onto irq.
  - 3 EDGE_CAP, R/W1C: writing 1 clears that bit; writing 0 has no effect.
  - 4 OUT_SET, WO: DATA_OUT |= writedata. Reads 0.
  - 5 OUT_CLR, WO: DATA_OUT &= ~writedata. Reads 0.
  - 6, 7: reserved. Read 0, writes ignored.
- Reset values:
  - DATA_OUT = RESET_VALUE, so out_port = RESET_VALUE.
  - IRQ_MASK = 0, EDGE_CAP = 0, irq = 0.
  - Synchroniser flops and prev register = 0.
  - readdata is combinational, so it reflects the reset register values.
- out_port:
  - equals DATA_OUT directly.
  - Updates on the clock edge that samples the write: 1 cycle after wr is asserted.
- Input path:
  - in_port passes through a SYNC_STAGES-deep flop chain. The chain output is sync_in, which is DATA_IN.
  - A change at in_port appears in DATA_IN after SYNC_STAGES rising edges.
  - prev register holds sync_in delayed by one cycle.
- Edge detection:
  - rise = sync_in & ~prev; fall = ~sync_in & prev.
  - ev = rise, fall, or (rise | fall) per EDGE_TYPE.
- Post-reset arming:
  - A saturating counter counts from reset deassertion. Edge detection is gated off until SYNC_STAGES+1 clocks have elapsed, and ev is forced 0 until then.
  - Purpose: an input already high at reset must not produce a spurious capture.
- Capture update per bit each clock: EDGE_CAP <= (EDGE_CAP & ~clr) | ev.
  - clr is writedata when wr and address == 3.
  - If a clear and a new event hit the same bit in the same cycle, set wins and the bit stays 1.
- Capture timing: a captured edge is visible in EDGE_CAP SYNC_STAGES+1 clocks after the in_port change.
- irq = |(EDGE_CAP & IRQ_MASK).
  - Combinational from registers.
  - Asserts in the same cycle EDGE_CAP or IRQ_MASK updates.
  - Remains asserted until every enabled capture bit is cleared or masked.
- OUT_SET and OUT_CLR are single-cycle read-modify-write with no race. Each access affects only the addressed register.
- Reset mid-operation:
  - All state returns to reset values immediately and asynchronously.
  - Arming restarts from 0 on reset deassertion.
- writedata bits above WIDTH are ignored for every register.

Test Plan:
- Reset: WIDTH=8, RESET_VALUE=8'hA5, hold in_port=8'hFF through reset and release. Required: out_port=8'hA5; EDGE_CAP reads 0 for 20 cycles; irq=0; DATA_IN=8'hFF after 2 clocks.
- Output ops: write DATA_OUT=8'h0F, then OUT_SET=8'hF0, then OUT_CLR=8'h3C. Required: out_port=8'h0F, 8'hFF, 8'hC3 on successive cycles; reading addresses 4 and 5 returns 0.
- Edge plus IRQ (EDGE_TYPE=0): IRQ_MASK=8'h01; drive in_port bit0 low to high. Required: EDGE_CAP=8'h01 and irq=1 exactly 3 clocks after the change; a falling edge causes no new capture; writing 8'h01 to address 3 gives irq=0 the next cycle.
- Masking: capture bit 3 with IRQ_MASK=0. Required: irq=0 and EDGE_CAP=8'h08. Writing IRQ_MASK=8'h08 gives irq=1 in the same cycle the mask register updates.
- Simultaneous clear and set: write 1 to EDGE_CAP bit2 in the same cycle a new bit2 edge is detected. Required: bit2 stays 1.
- Async reset mid-operation: out_port=8'h55, EDGE_CAP=8'h81; pulse reset_n low for half a cycle. Required: out_port=RESET_VALUE, EDGE_CAP=0 and irq=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/qsys_pio_gpio_edge.sv
// -----------------------------------------------------------------------------
// qsys_pio_gpio_edge
//
// Avalon-MM GPIO slave for the Nios II: a WIDTH-bit output register with
// atomic set/clear aliases, plus a synchronised WIDTH-bit input with per-bit
// edge capture and a maskable level interrupt. readdata is combinational
// (zero wait states, zero read latency).
//
// Register map (word offsets):
//   0 DATA_OUT  R/W   output register, drives out_port
//   1 DATA_IN   RO    synchronised input value
//   2 IRQ_MASK  R/W   1 = capture bit enabled onto irq
//   3 EDGE_CAP  R/W1C captured edges, write 1 to clear
//   4 OUT_SET   WO    DATA_OUT |= writedata, reads 0
//   5 OUT_CLR   WO    DATA_OUT &= ~writedata, reads 0
//   6,7         reserved, read 0
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   address     register word offset
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data (bits above WIDTH ignored)
//   readdata    read data, combinational from address
//   in_port     asynchronous external inputs
//   out_port    output register contents
//   irq         level interrupt, active high
// -----------------------------------------------------------------------------
module qsys_pio_gpio_edge #(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int          EDGE_TYPE   = 0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA_OUT = 3'd0;
    localparam logic [2:0] ADDR_DATA_IN  = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUT_SET  = 3'd4;
    localparam logic [2:0] ADDR_OUT_CLR  = 3'd5;

    // Edge detection stays off until the synchroniser and prev register have
    // both been refilled from the live input after reset.
    localparam logic [2:0] ARM_CNT = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0]                  r_data_out;
    logic [WIDTH-1:0]                  r_irq_mask;
    logic [WIDTH-1:0]                  r_edge_cap;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  r_prev;
    logic [2:0]                        r_arm_cnt;

    logic             w_wr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_sync_in;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_ev_raw;
    logic [WIDTH-1:0] w_ev;
    logic [WIDTH-1:0] w_clr;
    logic             w_armed;
    logic [31:0]      w_rdata;
    logic             w_unused_wdata;

    assign w_wr    = chipselect & ~write_n;
    assign w_wdata = writedata[WIDTH-1:0];

    // Upper writedata bits are deliberately ignored.
    assign w_unused_wdata = ^writedata;

    // -------------------------------------------------------------------------
    // Output register with set/clear aliases
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= RESET_VALUE[WIDTH-1:0];
        end else if (w_wr) begin
            case (address)
                ADDR_DATA_OUT: r_data_out <= w_wdata;
                ADDR_OUT_SET:  r_data_out <= r_data_out | w_wdata;
                ADDR_OUT_CLR:  r_data_out <= r_data_out & ~w_wdata;
                default:       r_data_out <= r_data_out;
            endcase
        end
    end

    assign out_port = r_data_out;

    // -------------------------------------------------------------------------
    // Interrupt mask
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_mask <= '0;
        end else if (w_wr && (address == ADDR_IRQ_MASK)) begin
            r_irq_mask <= w_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Input synchroniser and previous-value register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
            r_prev <= w_sync_in;
        end
    end

    assign w_sync_in = r_sync[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Post-reset arming counter (saturating)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_arm_cnt <= '0;
        end else if (!w_armed) begin
            r_arm_cnt <= r_arm_cnt + 3'd1;
        end
    end

    assign w_armed = (r_arm_cnt == ARM_CNT);

    // -------------------------------------------------------------------------
    // Edge detection
    // -------------------------------------------------------------------------
    assign w_rise = w_sync_in & ~r_prev;
    assign w_fall = ~w_sync_in & r_prev;

    always_comb begin
        w_ev_raw = w_rise;
        case (EDGE_TYPE)
            1:       w_ev_raw = w_fall;
            2:       w_ev_raw = w_rise | w_fall;
            default: w_ev_raw = w_rise;
        endcase
    end

    assign w_ev  = w_armed ? w_ev_raw : '0;
    assign w_clr = (w_wr && (address == ADDR_EDGE_CAP)) ? w_wdata : '0;

    // -------------------------------------------------------------------------
    // Edge capture: a new event beats a simultaneous W1C on the same bit.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_cap <= '0;
        end else begin
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_ev;
        end
    end

    assign irq = |(r_edge_cap & r_irq_mask);

    // -------------------------------------------------------------------------
    // Read mux
    // -------------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_DATA_OUT: w_rdata[WIDTH-1:0] = r_data_out;
            ADDR_DATA_IN:  w_rdata[WIDTH-1:0] = w_sync_in;
            ADDR_IRQ_MASK: w_rdata[WIDTH-1:0] = r_irq_mask;
            ADDR_EDGE_CAP: w_rdata[WIDTH-1:0] = r_edge_cap;
            default:       w_rdata = '0;
        endcase
    end

    assign readdata = w_rdata;

endmodule

// File: tb/tb_qsys_pio_gpio_edge.sv
module tb_qsys_pio_gpio_edge;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic [7:0]  out_port;
    logic        irq;

    int n_checks;
    int n_fail;
    logic [31:0] rd;

    qsys_pio_gpio_edge #(
        .WIDTH       (8),
        .RESET_VALUE (32'hA5),
        .EDGE_TYPE   (0),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic set_in(input logic [7:0] v);
        @(negedge clk);
        in_port = v;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        in_port    = 8'hFF;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;

        // Reset state with inputs already high
        tick(3);
        chk("rst_out_port", {24'h0, out_port}, 32'hA5);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        rd_reg(3'd3, rd); chk("rst_edge_cap", rd, 32'h0);
        rd_reg(3'd2, rd); chk("rst_irq_mask", rd, 32'h0);
        rd_reg(3'd0, rd); chk("rst_rd_data_out", rd, 32'hA5);
        @(negedge clk);
        reset_n = 1'b1;
        tick(1);
        rd_reg(3'd1, rd); chk("data_in_1clk", rd, 32'h0);
        tick(1);
        rd_reg(3'd1, rd); chk("data_in_2clk", rd, 32'hFF);
        for (int i = 0; i < 20; i++) begin
            rd_reg(3'd3, rd); chk("arm_no_capture", rd, 32'h0);
            chk("arm_no_irq", {31'h0, irq}, 32'h0);
            tick(1);
        end

        // Output register ops
        wr(3'd0, 32'h0000_000F); chk("out_write", {24'h0, out_port}, 32'h0F);
        wr(3'd4, 32'h0000_00F0); chk("out_set", {24'h0, out_port}, 32'hFF);
        wr(3'd5, 32'h0000_003C); chk("out_clr", {24'h0, out_port}, 32'hC3);
        rd_reg(3'd4, rd); chk("rd_out_set_zero", rd, 32'h0);
        rd_reg(3'd5, rd); chk("rd_out_clr_zero", rd, 32'h0);
        rd_reg(3'd0, rd); chk("rd_data_out", rd, 32'hC3);
        wr(3'd0, 32'h1234_565A); chk("out_upper_ignored", {24'h0, out_port}, 32'h5A);
        rd_reg(3'd0, rd); chk("rd_upper_zero", rd, 32'h5A);
        wr(3'd6, 32'hFFFF_FFFF);
        rd_reg(3'd6, rd); chk("rd_reserved6", rd, 32'h0);
        rd_reg(3'd7, rd); chk("rd_reserved7", rd, 32'h0);
        chk("reserved_no_effect", {24'h0, out_port}, 32'h5A);

        // Falling edges do not capture with rising-edge detection
        set_in(8'h00);
        tick(4);
        rd_reg(3'd3, rd); chk("fall_no_capture", rd, 32'h0);
        wr(3'd1, 32'hFF);
        rd_reg(3'd1, rd); chk("data_in_ro", rd, 32'h0);

        // Rising edge on bit0 with mask enabled: visible exactly 3 clocks later
        wr(3'd2, 32'h01);
        set_in(8'h01);
        tick(1);
        rd_reg(3'd3, rd); chk("cap_clk1", rd, 32'h0);
        tick(1);
        rd_reg(3'd3, rd); chk("cap_clk2", rd, 32'h0);
        chk("irq_clk2", {31'h0, irq}, 32'h0);
        tick(1);
        rd_reg(3'd3, rd); chk("cap_clk3", rd, 32'h01);
        chk("irq_clk3", {31'h0, irq}, 32'h1);
        set_in(8'h00);
        tick(4);
        rd_reg(3'd3, rd); chk("cap_after_fall", rd, 32'h01);
        wr(3'd3, 32'h00);
        rd_reg(3'd3, rd); chk("w0_no_clear", rd, 32'h01);
        wr(3'd3, 32'h01);
        chk("irq_cleared", {31'h0, irq}, 32'h0);
        rd_reg(3'd3, rd); chk("cap_cleared", rd, 32'h0);

        // Masked capture on bit3, then unmask
        wr(3'd2, 32'h00);
        set_in(8'h08);
        tick(3);
        rd_reg(3'd3, rd); chk("mask_cap", rd, 32'h08);
        chk("mask_irq_off", {31'h0, irq}, 32'h0);
        wr(3'd2, 32'h08);
        chk("unmask_irq_on", {31'h0, irq}, 32'h1);
        wr(3'd3, 32'h08);
        chk("unmask_irq_clr", {31'h0, irq}, 32'h0);

        // Clear and new edge on bit2 in the same cycle: set wins
        set_in(8'h0C);
        tick(3);
        rd_reg(3'd3, rd); chk("bit2_cap", rd, 32'h04);
        set_in(8'h08);
        tick(3);
        set_in(8'h0C);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        wr(3'd3, 32'h04);
        rd_reg(3'd3, rd); chk("set_wins", rd, 32'h04);
        wr(3'd3, 32'h04);
        rd_reg(3'd3, rd); chk("bit2_clear", rd, 32'h0);

        // Async reset mid-operation
        wr(3'd0, 32'h55);
        set_in(8'h8D);
        tick(3);
        wr(3'd2, 32'hFF);
        rd_reg(3'd3, rd); chk("pre_rst_cap", rd, 32'h81);
        chk("pre_rst_irq", {31'h0, irq}, 32'h1);
        chk("pre_rst_out", {24'h0, out_port}, 32'h55);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_out", {24'h0, out_port}, 32'hA5);
        chk("async_irq", {31'h0, irq}, 32'h0);
        rd_reg(3'd3, rd); chk("async_cap", rd, 32'h0);
        rd_reg(3'd2, rd); chk("async_mask", rd, 32'h0);
        #2;
        reset_n = 1'b1;
        tick(6);
        rd_reg(3'd1, rd); chk("rearm_data_in", rd, 32'h8D);
        rd_reg(3'd3, rd); chk("rearm_no_capture", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
